// File: rtl/peripheral_apb4_ahb3_master.sv
// -----------------------------------------------------------------------------
// peripheral_apb4_ahb3_master
//
// Bridges an APB4 slave port onto an AHB3-Lite master port, in a single
// clock domain (HCLK).
// Each APB access turns into one or more non-pipelined AHB SINGLE transfers.
// PREADY is held low until the AHB side has finished.
//
// Ports
//   HCLK, HRESET          clock and synchronous active-high reset
//   PSEL .. PPROT         APB4 request (select, enable, address, direction,
//                         write data, lane strobes, protection)
//   PRDATA, PREADY,       APB4 completion (read data, ready, error)
//   PSLVERR
//   HADDR .. HMASTLOCK    AHB3-Lite master request
//   HRDATA, HREADY, HRESP AHB3-Lite slave response (HREADY comes from the mux)
//
// Beat plan: if the strobes are 1111, 0011, 1100 or one-hot, the access is a
// single beat of the natural size.
// Any other pattern becomes one BYTE beat per set lane, in ascending order.
// A write with no strobes completes without touching AHB.
// -----------------------------------------------------------------------------
module peripheral_apb4_ahb3_master #(
    parameter int                    HADDR_SIZE = 32,
    parameter int                    HDATA_SIZE = 32,
    parameter int                    PADDR_SIZE = 10,
    parameter int                    PDATA_SIZE = 32,
    parameter logic [HADDR_SIZE-1:0] HADDR_BASE = '0
) (
    input  logic                    HCLK,
    input  logic                    HRESET,
    // APB4 slave port
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic [PADDR_SIZE-1:0]   PADDR,
    input  logic                    PWRITE,
    input  logic [PDATA_SIZE-1:0]   PWDATA,
    input  logic [PDATA_SIZE/8-1:0] PSTRB,
    input  logic [2:0]              PPROT,
    output logic [PDATA_SIZE-1:0]   PRDATA,
    output logic                    PREADY,
    output logic                    PSLVERR,
    // AHB3-Lite master port
    output logic [HADDR_SIZE-1:0]   HADDR,
    output logic [HDATA_SIZE-1:0]   HWDATA,
    input  logic [HDATA_SIZE-1:0]   HRDATA,
    output logic                    HWRITE,
    output logic [2:0]              HSIZE,
    output logic [2:0]              HBURST,
    output logic [3:0]              HPROT,
    output logic [1:0]              HTRANS,
    output logic                    HMASTLOCK,
    input  logic                    HREADY,
    input  logic                    HRESP
);

    localparam logic [2:0] SIZE_BYTE  = 3'b000;
    localparam logic [2:0] SIZE_HWORD = 3'b001;
    localparam logic [2:0] SIZE_WORD  = 3'b010;
    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;

    typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_RESP} state_t;

    state_t                  state_reg, state_next;
    logic [PADDR_SIZE-3:0]   word_reg;       // PADDR word index of the access
    logic [3:0]              rem_reg;        // lanes still to be transferred
    logic                    byte_mode_reg;  // access is split into byte beats
    logic [HADDR_SIZE-1:0]   haddr_reg;
    logic [2:0]              hsize_reg;
    logic                    hwrite_reg;
    logic [HDATA_SIZE-1:0]   hwdata_reg;
    logic [3:0]              hprot_reg;
    logic [PDATA_SIZE-1:0]   prdata_reg;
    logic                    pslverr_reg;

    logic                    setup;
    logic [3:0]              strb_in;
    logic                    byte_mode_in;
    logic [3:0]              plan_mask;
    logic                    plan_byte;
    logic [PADDR_SIZE-3:0]   plan_word;
    logic [1:0]              plan_off;
    logic [2:0]              plan_size;
    logic [3:0]              plan_rest;
    logic [HADDR_SIZE-1:0]   plan_haddr;

    logic unused_bits;
    assign unused_bits = ^{PPROT[1], PADDR[1:0]};

    assign setup   = PSEL & ~PENABLE;
    // Reads always fetch the whole word.
    assign strb_in = PWRITE ? PSTRB : 4'hF;
    assign byte_mode_in = !(strb_in inside {4'hF, 4'h3, 4'hC});

    // In IDLE, the planner works on the incoming request so that the first
    // beat can be loaded at capture time. After that, it works on the lanes
    // that remain.
    assign plan_mask = (state_reg == ST_IDLE) ? strb_in      : rem_reg;
    assign plan_byte = (state_reg == ST_IDLE) ? byte_mode_in : byte_mode_reg;
    assign plan_word = (state_reg == ST_IDLE) ? PADDR[PADDR_SIZE-1:2] : word_reg;

    always_comb begin
        plan_off  = 2'd0;
        plan_size = SIZE_BYTE;
        plan_rest = 4'h0;
        if (!plan_byte) begin
            case (plan_mask)
                4'hF:    plan_size = SIZE_WORD;
                4'h3:    plan_size = SIZE_HWORD;
                default: begin
                    plan_size = SIZE_HWORD;
                    plan_off  = 2'd2;
                end
            endcase
        end else begin
            // Scan downwards so the lowest set lane wins.
            for (int i = 3; i >= 0; i--) begin
                if (plan_mask[i]) begin
                    plan_off = 2'(i);
                end
            end
            plan_rest = plan_mask & ~(4'b0001 << plan_off);
        end
    end

    assign plan_haddr = HADDR_BASE + HADDR_SIZE'({plan_word, plan_off});

    // State register
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (setup) begin
                    state_next = (PWRITE && strb_in == 4'h0) ? ST_RESP : ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (HREADY) begin
                    state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (HREADY) begin
                    // An error completes the access and drops any remaining beats.
                    if (HRESP || rem_reg == 4'h0) begin
                        state_next = ST_RESP;
                    end else begin
                        state_next = ST_ADDR;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        HTRANS  = TRANS_IDLE;
        PREADY  = 1'b0;
        PSLVERR = 1'b0;
        if (state_reg == ST_ADDR) begin
            HTRANS = TRANS_NONSEQ;
        end
        // If the initiator drops PSEL early, the completion pulse is swallowed.
        if (state_reg == ST_RESP && PSEL) begin
            PREADY  = 1'b1;
            PSLVERR = pslverr_reg;
        end
    end

    // Request capture, beat sequencing and response registers
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            word_reg      <= '0;
            rem_reg       <= 4'h0;
            byte_mode_reg <= 1'b0;
            haddr_reg     <= '0;
            hsize_reg     <= SIZE_WORD;
            hwrite_reg    <= 1'b0;
            hwdata_reg    <= '0;
            hprot_reg     <= 4'b0011;
            prdata_reg    <= '0;
            pslverr_reg   <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (setup) begin
                        word_reg      <= PADDR[PADDR_SIZE-1:2];
                        byte_mode_reg <= byte_mode_in;
                        rem_reg       <= plan_rest;
                        haddr_reg     <= plan_haddr;
                        hsize_reg     <= plan_size;
                        hwrite_reg    <= PWRITE;
                        hwdata_reg    <= PWDATA;
                        hprot_reg     <= {2'b00, PPROT[0], ~PPROT[2]};
                        pslverr_reg   <= 1'b0;
                    end
                end
                ST_DATA: begin
                    if (HREADY) begin
                        if (HRESP) begin
                            pslverr_reg <= 1'b1;
                        end else begin
                            if (!hwrite_reg) begin
                                prdata_reg <= HRDATA;
                            end
                            if (rem_reg != 4'h0) begin
                                haddr_reg <= plan_haddr;
                                hsize_reg <= plan_size;
                                rem_reg   <= plan_rest;
                            end
                        end
                    end
                end
                ST_RESP: pslverr_reg <= 1'b0;
                default: ;
            endcase
        end
    end

    assign HADDR     = haddr_reg;
    assign HSIZE     = hsize_reg;
    assign HWRITE    = hwrite_reg;
    assign HWDATA    = hwdata_reg;
    assign HPROT     = hprot_reg;
    assign HBURST    = 3'b000;
    assign HMASTLOCK = 1'b0;
    assign PRDATA    = prdata_reg;

endmodule

// File: tb/tb_peripheral_apb4_ahb3_master.sv
// -----------------------------------------------------------------------------
// tb_peripheral_apb4_ahb3_master
//
// Directed bench for the APB4 -> AHB3-Lite bridge.
// An APB initiator task issues accesses and measures the cycle in which
// PREADY arrives, with the setup cycle counted as cycle 0.
// A small AHB slave model logs every NONSEQ beat. It can insert wait states
// or give a two-cycle ERROR response.
// -----------------------------------------------------------------------------
module tb_peripheral_apb4_ahb3_master;

    logic        HCLK;
    logic        HRESET;
    logic        PSEL;
    logic        PENABLE;
    logic [9:0]  PADDR;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;
    logic [2:0]  PPROT;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic [31:0] HADDR;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic [1:0]  HTRANS;
    logic        HMASTLOCK;
    logic        HREADY;
    logic        HRESP;

    peripheral_apb4_ahb3_master dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PADDR     (PADDR),
        .PWRITE    (PWRITE),
        .PWDATA    (PWDATA),
        .PSTRB     (PSTRB),
        .PPROT     (PPROT),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR),
        .HADDR     (HADDR),
        .HWDATA    (HWDATA),
        .HRDATA    (HRDATA),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HBURST    (HBURST),
        .HPROT     (HPROT),
        .HTRANS    (HTRANS),
        .HMASTLOCK (HMASTLOCK),
        .HREADY    (HREADY),
        .HRESP     (HRESP)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- AHB slave model ----------------
    int          wait_cfg  = 0;
    bit          err_cfg   = 1'b0;
    logic [31:0] rdata_cfg = 32'h0;
    int          beat_cnt  = 0;
    logic [31:0] beat_addr  [0:7];
    logic [2:0]  beat_size  [0:7];
    logic        beat_write [0:7];
    logic [3:0]  beat_prot  [0:7];
    logic [31:0] beat_wdata [0:7];

    initial begin
        int idx;
        HREADY = 1'b1;
        HRESP  = 1'b0;
        HRDATA = 32'h0;
        forever begin
            @(negedge HCLK);
            if (HTRANS == 2'b10 && HREADY) begin
                idx = beat_cnt;
                if (idx < 8) begin
                    beat_addr[idx]  = HADDR;
                    beat_size[idx]  = HSIZE;
                    beat_write[idx] = HWRITE;
                    beat_prot[idx]  = HPROT;
                end
                beat_cnt++;
                @(posedge HCLK); #1;
                for (int w = 0; w < wait_cfg; w++) begin
                    HREADY = 1'b0;
                    @(posedge HCLK); #1;
                end
                if (err_cfg) begin
                    HREADY = 1'b0;
                    HRESP  = 1'b1;
                    @(posedge HCLK); #1;
                    HREADY = 1'b1;
                    HRESP  = 1'b1;
                end else begin
                    HREADY = 1'b1;
                    HRDATA = rdata_cfg;
                end
                @(negedge HCLK);
                if (idx < 8) beat_wdata[idx] = HWDATA;
                @(posedge HCLK); #1;
                HREADY = 1'b1;
                HRESP  = 1'b0;
                HRDATA = 32'h0;
            end
        end
    end

    // ---------------- APB initiator ----------------
    // Called just after a rising edge; that cycle is the setup cycle (cycle 0).
    task automatic apb_xfer(input string tag, input logic [9:0] addr, input bit wr,
                            input logic [31:0] wd, input logic [3:0] strb, input logic [2:0] prot,
                            output int lat, output logic [31:0] rd, output logic err);
        lat     = -1;
        rd      = 32'hx;
        err     = 1'bx;
        beat_cnt = 0;
        PSEL    = 1'b1;
        PENABLE = 1'b0;
        PADDR   = addr;
        PWRITE  = wr;
        PWDATA  = wd;
        PSTRB   = strb;
        PPROT   = prot;
        for (int c = 0; c < 40; c++) begin
            @(negedge HCLK);
            if (PREADY) begin
                lat = c;
                rd  = PRDATA;
                err = PSLVERR;
                break;
            end
            @(posedge HCLK); #1;
            PENABLE = 1'b1;
        end
        @(posedge HCLK); #1;
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        @(negedge HCLK);
        check_eq({tag, "_pready_one_cycle"}, 32'(PREADY), 32'd0);
        @(posedge HCLK); #1;
        $display("[TB] xfer %s addr=0x%03h wr=%0d strb=%04b lat=%0d beats=%0d err=%0d rd=0x%08h",
                 tag, addr, wr, strb, lat, beat_cnt, err, rd);
    endtask

    int          lat;
    logic [31:0] rd;
    logic        err;
    bit          pready_seen;

    initial begin
        HRESET  = 1'b1;
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        PADDR   = '0;
        PWRITE  = 1'b0;
        PWDATA  = '0;
        PSTRB   = '0;
        PPROT   = '0;

        repeat (3) @(posedge HCLK);
        @(negedge HCLK);
        check_eq("rst_pready",  32'(PREADY),    32'd0);
        check_eq("rst_pslverr", 32'(PSLVERR),   32'd0);
        check_eq("rst_prdata",  PRDATA,         32'h0);
        check_eq("rst_htrans",  32'(HTRANS),    32'd0);
        check_eq("rst_haddr",   HADDR,          32'h0);
        check_eq("rst_hwdata",  HWDATA,         32'h0);
        check_eq("rst_hwrite",  32'(HWRITE),    32'd0);
        check_eq("rst_hsize",   32'(HSIZE),     32'd2);
        check_eq("rst_hprot",   32'(HPROT),     32'h3);
        check_eq("rst_hburst",  32'(HBURST),    32'd0);
        check_eq("rst_hmlock",  32'(HMASTLOCK), 32'd0);
        @(posedge HCLK); #1;
        HRESET = 1'b0;
        @(posedge HCLK); #1;

        // Full-word write, zero-wait slave
        apb_xfer("wr_word", 10'h004, 1'b1, 32'hDEADBEEF, 4'hF, 3'b001, lat, rd, err);
        check_eq("wr_word_lat",   32'(lat),           32'd3);
        check_eq("wr_word_err",   32'(err),           32'd0);
        check_eq("wr_word_beats", 32'(beat_cnt),      32'd1);
        check_eq("wr_word_addr",  beat_addr[0],       32'h004);
        check_eq("wr_word_size",  32'(beat_size[0]),  32'd2);
        check_eq("wr_word_write", 32'(beat_write[0]), 32'd1);
        check_eq("wr_word_prot",  32'(beat_prot[0]),  32'h3);
        check_eq("wr_word_wdata", beat_wdata[0],      32'hDEADBEEF);

        // Read with two wait states; PSTRB is ignored for reads
        wait_cfg  = 2;
        rdata_cfg = 32'h12345678;
        apb_xfer("rd_wait2", 10'h008, 1'b0, 32'h0, 4'h0, 3'b000, lat, rd, err);
        wait_cfg  = 0;
        check_eq("rd_lat",    32'(lat),           32'd5);
        check_eq("rd_data",   rd,                 32'h12345678);
        check_eq("rd_err",    32'(err),           32'd0);
        check_eq("rd_beats",  32'(beat_cnt),      32'd1);
        check_eq("rd_addr",   beat_addr[0],       32'h008);
        check_eq("rd_size",   32'(beat_size[0]),  32'd2);
        check_eq("rd_hwrite", 32'(beat_write[0]), 32'd0);
        check_eq("rd_prot",   32'(beat_prot[0]),  32'h1);

        // Sparse strobes 0101 -> two byte beats at lanes 0 and 2
        apb_xfer("wr_0101", 10'h010, 1'b1, 32'hAABBCCDD, 4'b0101, 3'b000, lat, rd, err);
        check_eq("wr_0101_lat",    32'(lat),          32'd5);
        check_eq("wr_0101_beats",  32'(beat_cnt),     32'd2);
        check_eq("wr_0101_addr0",  beat_addr[0],      32'h010);
        check_eq("wr_0101_size0",  32'(beat_size[0]), 32'd0);
        check_eq("wr_0101_wdata0", beat_wdata[0],     32'hAABBCCDD);
        check_eq("wr_0101_addr1",  beat_addr[1],      32'h012);
        check_eq("wr_0101_size1",  32'(beat_size[1]), 32'd0);
        check_eq("wr_0101_wdata1", beat_wdata[1],     32'hAABBCCDD);

        // Upper half-word
        apb_xfer("wr_1100", 10'h020, 1'b1, 32'h55667788, 4'b1100, 3'b000, lat, rd, err);
        check_eq("wr_1100_lat",   32'(lat),          32'd3);
        check_eq("wr_1100_beats", 32'(beat_cnt),     32'd1);
        check_eq("wr_1100_addr",  beat_addr[0],      32'h022);
        check_eq("wr_1100_size",  32'(beat_size[0]), 32'd1);

        // No strobes: completes without any AHB transfer
        apb_xfer("wr_0000", 10'h024, 1'b1, 32'h11111111, 4'b0000, 3'b000, lat, rd, err);
        check_eq("wr_0000_lat",   32'(lat),      32'd1);
        check_eq("wr_0000_beats", 32'(beat_cnt), 32'd0);
        check_eq("wr_0000_err",   32'(err),      32'd0);

        // Two-cycle ERROR on the first of three byte beats
        err_cfg = 1'b1;
        apb_xfer("wr_err", 10'h030, 1'b1, 32'h01020304, 4'b1011, 3'b000, lat, rd, err);
        err_cfg = 1'b0;
        check_eq("wr_err_lat",   32'(lat),          32'd4);
        check_eq("wr_err_err",   32'(err),          32'd1);
        check_eq("wr_err_beats", 32'(beat_cnt),     32'd1);
        check_eq("wr_err_addr",  beat_addr[0],      32'h030);
        check_eq("wr_err_size",  32'(beat_size[0]), 32'd0);
        @(negedge HCLK);
        check_eq("wr_err_pslverr_clr", 32'(PSLVERR), 32'd0);
        @(posedge HCLK); #1;

        // Reset while the read is waiting in its data phase
        wait_cfg = 3;
        beat_cnt = 0;
        PSEL    = 1'b1;
        PENABLE = 1'b0;
        PADDR   = 10'h040;
        PWRITE  = 1'b0;
        PSTRB   = 4'hF;
        @(posedge HCLK); #1;
        PENABLE = 1'b1;
        @(posedge HCLK); #1;
        HRESET = 1'b1;
        @(posedge HCLK); #1;
        HRESET  = 1'b0;
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        @(negedge HCLK);
        check_eq("rst_mid_htrans", 32'(HTRANS), 32'd0);
        check_eq("rst_mid_pready", 32'(PREADY), 32'd0);
        check_eq("rst_mid_haddr",  HADDR,       32'h0);
        pready_seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge HCLK);
            if (PREADY) pready_seen = 1'b1;
        end
        check_eq("rst_mid_no_pready", 32'(pready_seen), 32'd0);
        check_eq("rst_mid_beats",     32'(beat_cnt),    32'd1);
        wait_cfg = 0;
        @(posedge HCLK); #1;
        $display("[TB] xfer rst_mid addr=0x040 abandoned by reset");

        // Normal access after the reset, lower half-word and non-default protection
        apb_xfer("wr_after_rst", 10'h03C, 1'b1, 32'hCAFEF00D, 4'b0011, 3'b101, lat, rd, err);
        check_eq("after_rst_lat",   32'(lat),          32'd3);
        check_eq("after_rst_beats", 32'(beat_cnt),     32'd1);
        check_eq("after_rst_addr",  beat_addr[0],      32'h03C);
        check_eq("after_rst_size",  32'(beat_size[0]), 32'd1);
        check_eq("after_rst_prot",  32'(beat_prot[0]), 32'h2);
        check_eq("after_rst_wdata", beat_wdata[0],     32'hCAFEF00D);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/peripheral_apb4_ahb3_master.md
Name: peripheral_apb4_ahb3_master

Overview:
- Single-clock bridge with an APB4 slave port and an AHB3-Lite master port.
- Lets an APB4 initiator (debug/config master) reach AHB3-Lite slaves, such as GPIO behind the AHB slave interface.
- Each APB access becomes one or more non-pipelined AHB SINGLE transfers, with PREADY stretched until the AHB side completes.

Parameters:
- HADDR_SIZE, 32, AHB address width.
- HDATA_SIZE, 32, AHB data width; must equal PDATA_SIZE.
- PADDR_SIZE, 10, APB address width.
- PDATA_SIZE, 32, APB data width; must equal HDATA_SIZE; fixed at 32.
- HADDR_BASE, 0, added to the zero-extended PADDR to form HADDR.

Ports:
- HCLK  in  1  sole clock, both ports.
- HRESET  in  1  synchronous, active-high reset.
- PSEL  in  1  APB select.
- PENABLE  in  1  APB access phase.
- PADDR  in  PADDR_SIZE  APB address.
- PWRITE  in  1  APB direction.
- PWDATA  in  PDATA_SIZE  APB write data.
- PSTRB  in  PDATA_SIZE/8  APB write lane strobes.
- PPROT  in  3  APB protection.
- PRDATA  out  PDATA_SIZE  read data.
- PREADY  out  1  transfer complete.
- PSLVERR  out  1  error, valid with PREADY.
- HADDR  out  HADDR_SIZE  AHB address.
- HWDATA  out  HDATA_SIZE  AHB write data.
- HRDATA  in  HDATA_SIZE  AHB read data.
- HWRITE  out  1  AHB direction.
- HSIZE  out  3  AHB size.
- HBURST  out  3  AHB burst, constant SINGLE.
- HPROT  out  4  AHB protection.
- HTRANS  out  2  AHB transfer type.
- HMASTLOCK  out  1  constant 0.
- HREADY  in  1  AHB ready (from mux).
- HRESP  in  1  AHB response, 0=OKAY, 1=ERROR.

Behaviour:
- Reset values: PREADY=0, PSLVERR=0, PRDATA=0, HTRANS=IDLE, HADDR=0, HWDATA=0, HWRITE=0, HSIZE=WORD, HPROT=4'b0011, HBURST=SINGLE, HMASTLOCK=0.
- Reset is sampled every edge. Mid-operation it forces IDLE and abandons the AHB transfer; no PREADY is issued.
- FSM states: IDLE, ADDR, DATA, RESP.
- IDLE:
  - On PSEL & ~PENABLE (setup phase), capture PADDR, PWRITE, PWDATA, PSTRB, PPROT; go to ADDR.
  - For a read, treat PSTRB as 4'b1111.
- Beat plan from the captured strobes:
  - 1111 gives one WORD beat, HADDR[1:0]=00.
  - 0011 gives one HWORD beat at 00; 1100 gives one HWORD beat at 10.
  - A single set bit n gives one BYTE beat at HADDR[1:0]=n.
  - Any other pattern gives BYTE beats for each set bit in ascending lane order.
  - 0000 write: no AHB transfer; go directly to RESP with PSLVERR=0.
- HADDR = HADDR_BASE + {PADDR[PADDR_SIZE-1:2], lane offset}.
- HPROT = {2'b00, PPROT[0], ~PPROT[2]}.
- ADDR:
  - Drive HTRANS=NONSEQ with HADDR, HWRITE, HSIZE.
  - Hold until HREADY=1 at a rising edge, then go to DATA with HTRANS=IDLE.
- DATA:
  - Drive HWDATA = captured PWDATA; lanes are unshifted, since widths are equal.
  - On HREADY=1 & HRESP=0: for reads, capture HRDATA into PRDATA. If beats remain, go to ADDR with the next lane; else go to RESP with PSLVERR=0.
  - On HRESP=1 & HREADY=0 (first error cycle): keep HTRANS=IDLE.
  - On HRESP=1 & HREADY=1: go to RESP with PSLVERR=1. Remaining beats are aborted.
- RESP:
  - Assert PREADY=1 for exactly one cycle, then return to IDLE with PREADY=0 and PSLVERR=0.
  - If PSEL is low in RESP (protocol violation), suppress the PREADY pulse and return to IDLE.
- Latency, single-beat, zero-wait AHB: setup at cycle 0; NONSEQ in cycle 1; data in cycle 2; PREADY in cycle 3. Each extra beat adds 2 cycles; each AHB wait state adds 1 cycle.
- PREADY is never high outside RESP.
- A new setup is accepted only in IDLE. Back-to-back APB transfers are supported: a setup in the cycle after RESP is accepted.

Test Plan:
- Write, PADDR=0x004, PSTRB=1111, PWDATA=0xDEADBEEF, zero-wait AHB -> one NONSEQ, HADDR=0x004, HSIZE=WORD, HWDATA=0xDEADBEEF, PREADY=1 in cycle 3, PSLVERR=0.
- Read, PADDR=0x008, slave inserts 2 wait states and returns 0x12345678 -> PREADY in cycle 5, PRDATA=0x12345678, HWRITE=0.
- Write, PSTRB=0101, PADDR=0x010, PWDATA=0xAABBCCDD -> two BYTE NONSEQs, at 0x010 then 0x012, HWDATA=0xAABBCCDD both; PREADY in cycle 5.
- Write, PSTRB=1100 -> single HWORD at HADDR[1:0]=10. Write, PSTRB=0000 -> no NONSEQ; PREADY in cycle 1.
- Write, PSTRB=1011, AHB two-cycle ERROR on first beat -> no second beat issued, PREADY=1 with PSLVERR=1.
- HRESET asserted while in DATA -> next cycle HTRANS=IDLE, PREADY=0; following setup phase is processed normally.
